// File: rtl/regfile_mp.sv
// regfile_mp: multi-port general-purpose register file for the NPC core.
// NRP combinational read ports, two write-back ports (port 1 wins on a
// same-address collision), a per-register busy scoreboard for hazard
// detection, and a handshaked engine that streams every register to the
// difftest/debug side.
// Optional feature macro: REGFILE_BYPASS_EN. When it is defined, reads
// forward same-cycle write data and rbusy forwards same-cycle clears.
module regfile_mp #(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    parameter  int NRP  = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRP*AW-1:0]     raddr,
    output logic [NRP*XLEN-1:0]   rdata,
    output logic [NRP-1:0]        rbusy,
    input  logic                  we0,
    input  logic [AW-1:0]         waddr0,
    input  logic [XLEN-1:0]       wdata0,
    input  logic                  we1,
    input  logic [AW-1:0]         waddr1,
    input  logic [XLEN-1:0]       wdata1,
    input  logic                  alloc_valid,
    input  logic [AW-1:0]         alloc_addr,
    input  logic                  sb_flush,
    input  logic                  dump_start,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [AW-1:0]         dump_idx,
    output logic [XLEN-1:0]       dump_data,
    output logic                  dump_busy,
    output logic                  dump_done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DUMP,
        ST_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic [AW-1:0]   idx;
    logic [AW-1:0]   idx_nxt;

    // Register array: port 1 takes priority over port 0; x0 stays zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            regs[0] <= '0;
            for (int unsigned i = 1; i < NREG; i++) begin
                if (we1 && (waddr1 == AW'(i))) begin
                    regs[i] <= wdata1;
                end else if (we0 && (waddr0 == AW'(i))) begin
                    regs[i] <= wdata0;
                end
            end
        end
    end

    // Scoreboard next state: alloc beats a same-cycle write clear, flush beats all.
    always_comb begin
        busy_nxt = busy;
        for (int unsigned i = 1; i < NREG; i++) begin
            if (alloc_valid && (alloc_addr == AW'(i))) begin
                busy_nxt[i] = 1'b1;
            end else if ((we0 && (waddr0 == AW'(i))) || (we1 && (waddr1 == AW'(i)))) begin
                busy_nxt[i] = 1'b0;
            end
        end
        busy_nxt[0] = 1'b0;
        if (sb_flush) begin
            busy_nxt = '0;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Read ports: array value (optionally forwarded), x0 forced to zero.
    always_comb begin
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd;
        logic            bz;
        rdata = '0;
        rbusy = '0;
        ra    = '0;
        rd    = '0;
        bz    = 1'b0;
        for (int unsigned k = 0; k < NRP; k++) begin
            ra = raddr[k*AW +: AW];
            rd = regs[ra];
            bz = busy[ra];
`ifdef REGFILE_BYPASS_EN
            if (we1 && (waddr1 == ra)) begin
                rd = wdata1;
            end else if (we0 && (waddr0 == ra)) begin
                rd = wdata0;
            end
            if (((we0 && (waddr0 == ra)) || (we1 && (waddr1 == ra))) &&
                !(alloc_valid && (alloc_addr == ra))) begin
                bz = 1'b0;
            end
`else
            rd = regs[ra];
            bz = busy[ra];
`endif
            if (ra == '0) begin
                rd = '0;
                bz = 1'b0;
            end
            rdata[k*XLEN +: XLEN] = rd;
            rbusy[k]              = bz;
        end
    end

    // Dump FSM state and index registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Dump FSM next state and beat outputs.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        dump_valid = 1'b0;
        dump_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dump_start) begin
                    state_nxt = ST_DUMP;
                    idx_nxt   = '0;
                end
            end
            ST_DUMP: begin
                dump_valid = 1'b1;
                if (dump_ready) begin
                    idx_nxt = idx + AW'(1);
                    if (idx == AW'(NREG - 1)) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                dump_done = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign dump_idx  = idx;
    assign dump_busy = (state != ST_IDLE);
    assign dump_data = (dump_valid && (idx != '0)) ? regs[idx] : '0;

endmodule
